// File: rtl/bp_me_dma_initiator.sv
// Block-level DMA initiator: turns one block read/write request into a DMA packet
// plus a burst of fill-width data beats, then returns a single block completion.
module bp_me_dma_initiator #(
    parameter int daddr_width_p        = 28,
    parameter int fill_width_p         = 64,
    parameter int block_size_in_fill_p = 8,
    localparam int blockWidthLp        = fill_width_p * block_size_in_fill_p,
    localparam int dmaPktWidthLp       = 1 + daddr_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     req_v_i,
    output logic                     req_ready_and_o,
    input  logic                     req_write_not_read_i,
    input  logic [daddr_width_p-1:0] req_addr_i,
    input  logic [blockWidthLp-1:0]  req_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_ready_and_i,
    output logic                     resp_write_not_read_o,
    output logic [blockWidthLp-1:0]  resp_data_o,

    output logic [dmaPktWidthLp-1:0] dma_pkt_o,
    output logic                     dma_pkt_v_o,
    input  logic                     dma_pkt_yumi_i,

    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,

    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_yumi_i
);

    localparam int cntWidthLp   = (block_size_in_fill_p > 1) ? $clog2(block_size_in_fill_p) : 1;
    localparam int offsetBitsLp = $clog2(blockWidthLp / 8);
    localparam logic [cntWidthLp-1:0]    lastBeatLp  = cntWidthLp'(block_size_in_fill_p - 1);
    localparam logic [daddr_width_p-1:0] addrMaskLp  = {daddr_width_p{1'b1}} << offsetBitsLp;

    typedef enum logic [2:0] {
        e_ready,
        e_send_pkt,
        e_write_data,
        e_read_data,
        e_resp
    } state_e;

    state_e                    state_q, state_d;
    logic                      writeNotRead_q, writeNotRead_d;
    logic [daddr_width_p-1:0]  addr_q, addr_d;
    logic [blockWidthLp-1:0]   data_q, data_d;
    logic [cntWidthLp-1:0]     beatCnt_q, beatCnt_d;
    logic                      readyEn_q;

    // readyEn_q keeps req_ready low while reset is held and until the first clock after release
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= e_ready;
            writeNotRead_q <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            beatCnt_q      <= '0;
            readyEn_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            writeNotRead_q <= writeNotRead_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            beatCnt_q      <= beatCnt_d;
            readyEn_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        writeNotRead_d = writeNotRead_q;
        addr_d         = addr_q;
        data_d         = data_q;
        beatCnt_d      = beatCnt_q;

        case (state_q)
            e_ready: begin
                if (req_v_i && req_ready_and_o) begin
                    writeNotRead_d = req_write_not_read_i;
                    addr_d         = req_addr_i & addrMaskLp;
                    data_d         = req_data_i;
                    state_d        = e_send_pkt;
                end
            end
            e_send_pkt: begin
                if (dma_pkt_yumi_i) begin
                    beatCnt_d = '0;
                    state_d   = writeNotRead_q ? e_write_data : e_read_data;
                end
            end
            e_write_data: begin
                if (dma_data_yumi_i) begin
                    if (beatCnt_q == lastBeatLp) begin
                        state_d = e_resp;
                    end else begin
                        beatCnt_d = beatCnt_q + cntWidthLp'(1);
                    end
                end
            end
            e_read_data: begin
                if (dma_data_v_i) begin
                    data_d[beatCnt_q*fill_width_p +: fill_width_p] = dma_data_i;
                    if (beatCnt_q == lastBeatLp) begin
                        state_d = e_resp;
                    end else begin
                        beatCnt_d = beatCnt_q + cntWidthLp'(1);
                    end
                end
            end
            e_resp: begin
                if (resp_ready_and_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    assign req_ready_and_o       = (state_q == e_ready) && readyEn_q;
    assign dma_pkt_v_o           = (state_q == e_send_pkt);
    assign dma_pkt_o             = {writeNotRead_q, addr_q};
    assign dma_data_v_o          = (state_q == e_write_data);
    assign dma_data_o            = data_q[beatCnt_q*fill_width_p +: fill_width_p];
    assign dma_data_ready_and_o  = (state_q == e_read_data);
    assign resp_v_o              = (state_q == e_resp);
    assign resp_write_not_read_o = writeNotRead_q;
    assign resp_data_o           = data_q;

endmodule

// File: tb/tb_bp_me_dma_initiator.sv
// Directed bench for bp_me_dma_initiator: an 8-beat instance and a 1-beat instance
// share clock and reset and are checked against hand-computed packets and blocks.
module tb_bp_me_dma_initiator;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-beat instance
    logic          reqV, reqReady, reqWnr, respV, respReady, respWnr;
    logic [27:0]   reqAddr;
    logic [511:0]  reqData, respData;
    logic [28:0]   pkt;
    logic          pktV, pktYumi;
    logic [63:0]   dIn, dOut;
    logic          dInV, dInReady, dOutV, dOutYumi;

    // 1-beat instance
    logic          sReqV, sReqReady, sReqWnr, sRespV, sRespReady, sRespWnr;
    logic [27:0]   sReqAddr;
    logic [63:0]   sReqData, sRespData;
    logic [28:0]   sPkt;
    logic          sPktV, sPktYumi;
    logic [63:0]   sDIn, sDOut;
    logic          sDInV, sDInReady, sDOutV, sDOutYumi;

    logic [511:0]  expBlk, wBlk;
    int            idx;

    bp_me_dma_initiator dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(reqV), .req_ready_and_o(reqReady), .req_write_not_read_i(reqWnr),
        .req_addr_i(reqAddr), .req_data_i(reqData),
        .resp_v_o(respV), .resp_ready_and_i(respReady), .resp_write_not_read_o(respWnr),
        .resp_data_o(respData),
        .dma_pkt_o(pkt), .dma_pkt_v_o(pktV), .dma_pkt_yumi_i(pktYumi),
        .dma_data_i(dIn), .dma_data_v_i(dInV), .dma_data_ready_and_o(dInReady),
        .dma_data_o(dOut), .dma_data_v_o(dOutV), .dma_data_yumi_i(dOutYumi)
    );

    bp_me_dma_initiator #(.block_size_in_fill_p(1)) dutSingle (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(sReqV), .req_ready_and_o(sReqReady), .req_write_not_read_i(sReqWnr),
        .req_addr_i(sReqAddr), .req_data_i(sReqData),
        .resp_v_o(sRespV), .resp_ready_and_i(sRespReady), .resp_write_not_read_o(sRespWnr),
        .resp_data_o(sRespData),
        .dma_pkt_o(sPkt), .dma_pkt_v_o(sPktV), .dma_pkt_yumi_i(sPktYumi),
        .dma_data_i(sDIn), .dma_data_v_i(sDInV), .dma_data_ready_and_o(sDInReady),
        .dma_data_o(sDOut), .dma_data_v_o(sDOutV), .dma_data_yumi_i(sDOutYumi)
    );

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        reqV = 0; reqWnr = 0; reqAddr = '0; reqData = '0; respReady = 0;
        pktYumi = 0; dIn = '0; dInV = 0; dOutYumi = 0;
        sReqV = 0; sReqWnr = 0; sReqAddr = '0; sReqData = '0; sRespReady = 0;
        sPktYumi = 0; sDIn = '0; sDInV = 0; sDOutYumi = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus();
        #3;
        checkOutput("rst_req_ready", reqReady, 0);
        checkOutput("rst_resp_v", respV, 0);
        checkOutput("rst_pkt_v", pktV, 0);
        checkOutput("rst_data_v", dOutV, 0);
        checkOutput("rst_data_ready", dInReady, 0);
        checkOutput("rst_resp_data", respData, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        #1 checkOutput("ready_before_edge", reqReady, 0);
        tick();
        checkOutput("ready_after_edge", reqReady, 1);
        checkOutput("single_ready_after_edge", sReqReady, 1);

        // Read at 0x0012345, beats 0..7, response stall of 3 cycles with req_v high
        reqV = 1; reqWnr = 0; reqAddr = 28'h0012345;
        tick();
        reqV = 0;
        checkOutput("rd_pkt_v", pktV, 1);
        checkOutput("rd_pkt", pkt, {1'b0, 28'h0012340});
        checkOutput("rd_req_ready_low", reqReady, 0);
        pktYumi = 1;
        tick();
        pktYumi = 0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("rd_data_ready", dInReady, 1);
            expBlk[k*64 +: 64] = 64'(k);
            dInV = 1; dIn = 64'(k);
            tick();
        end
        dInV = 0;
        reqV = 1; reqAddr = 28'h100;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rd_resp_v", respV, 1);
            checkOutput("rd_resp_wnr", respWnr, 0);
            checkOutput("rd_resp_data", respData, expBlk);
            checkOutput("rd_stall_req_ready", reqReady, 0);
            tick();
        end
        respReady = 1;
        tick();
        respReady = 0; reqV = 0;
        checkOutput("rd_resp_done", respV, 0);
        checkOutput("rd_req_ready_back", reqReady, 1);

        // Write at 0x80, yumi toggled every other cycle, packet yumi held off 5 cycles
        for (int k = 0; k < 8; k++) wBlk[k*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(k);
        reqV = 1; reqWnr = 1; reqAddr = 28'h0000080; reqData = wBlk;
        tick();
        reqV = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("wr_pkt_v", pktV, 1);
            checkOutput("wr_pkt", pkt, {1'b1, 28'h0000080});
            checkOutput("wr_pkt_req_ready", reqReady, 0);
            checkOutput("wr_pkt_data_ready", dInReady, 0);
            tick();
        end
        pktYumi = 1;
        tick();
        pktYumi = 0;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            checkOutput("wr_data_v", dOutV, 1);
            checkOutput("wr_beat", dOut, wBlk[idx*64 +: 64]);
            checkOutput("wr_data_ready", dInReady, 0);
            dOutYumi = c[0];
            tick();
            if (c[0]) idx++;
        end
        dOutYumi = 0;
        checkOutput("wr_data_v_done", dOutV, 0);
        checkOutput("wr_resp_v", respV, 1);
        checkOutput("wr_resp_wnr", respWnr, 1);
        checkOutput("wr_resp_data", respData, wBlk);
        respReady = 1;
        tick();
        respReady = 0;
        checkOutput("wr_req_ready_back", reqReady, 1);

        // Read interrupted by reset after 3 beats, then a fresh read of 0x40
        reqV = 1; reqWnr = 0; reqAddr = 28'h40;
        tick();
        reqV = 0; pktYumi = 1;
        tick();
        pktYumi = 0;
        for (int k = 0; k < 3; k++) begin
            dInV = 1; dIn = 64'hBAD0 + 64'(k);
            tick();
        end
        dInV = 0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_data_ready", dInReady, 0);
        checkOutput("mid_rst_req_ready", reqReady, 0);
        checkOutput("mid_rst_resp_v", respV, 0);
        checkOutput("mid_rst_pkt_v", pktV, 0);
        checkOutput("mid_rst_data_v", dOutV, 0);
        checkOutput("mid_rst_resp_data", respData, 0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", reqReady, 1);
        reqV = 1; reqAddr = 28'h40;
        tick();
        reqV = 0;
        checkOutput("rd2_pkt", pkt, {1'b0, 28'h40});
        pktYumi = 1;
        tick();
        pktYumi = 0;
        for (int k = 0; k < 8; k++) begin
            expBlk[k*64 +: 64] = 64'h1000 + 64'(k);
            dInV = 1; dIn = 64'h1000 + 64'(k);
            tick();
        end
        dInV = 0;
        checkOutput("rd2_resp_v", respV, 1);
        checkOutput("rd2_resp_data", respData, expBlk);
        respReady = 1;
        tick();
        respReady = 0;

        // Single-beat instance: read then write
        sReqV = 1; sReqWnr = 0; sReqAddr = 28'h13;
        tick();
        sReqV = 0;
        checkOutput("s_rd_pkt", sPkt, {1'b0, 28'h10});
        sPktYumi = 1;
        tick();
        sPktYumi = 0;
        checkOutput("s_rd_data_ready", sDInReady, 1);
        sDInV = 1; sDIn = 64'h1122_3344_5566_7788;
        tick();
        sDInV = 0;
        checkOutput("s_rd_resp_v", sRespV, 1);
        checkOutput("s_rd_resp_wnr", sRespWnr, 0);
        checkOutput("s_rd_resp_data", sRespData, 64'h1122_3344_5566_7788);
        sRespReady = 1;
        tick();
        sRespReady = 0;
        sReqV = 1; sReqWnr = 1; sReqAddr = 28'h20; sReqData = 64'hCAFE_F00D_0BAD_BEEF;
        tick();
        sReqV = 0;
        checkOutput("s_wr_pkt", sPkt, {1'b1, 28'h20});
        sPktYumi = 1;
        tick();
        sPktYumi = 0;
        checkOutput("s_wr_data_v", sDOutV, 1);
        checkOutput("s_wr_beat", sDOut, 64'hCAFE_F00D_0BAD_BEEF);
        sDOutYumi = 1;
        tick();
        sDOutYumi = 0;
        checkOutput("s_wr_data_v_done", sDOutV, 0);
        checkOutput("s_wr_resp_v", sRespV, 1);
        checkOutput("s_wr_resp_wnr", sRespWnr, 1);
        checkOutput("s_wr_resp_data", sRespData, 64'hCAFE_F00D_0BAD_BEEF);
        sRespReady = 1;
        tick();
        sRespReady = 0;
        checkOutput("s_ready_back", sReqReady, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
